// File: rtl/mult_arbiter_if.sv
// Bus between the requesters/consumer/multiplier and mult_arbiter.
// The arbiter uses the slave modport. The master modport is the environment's
// view: requesters, response consumer and the multiplier datapath.
interface mult_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  // Requester side
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_m;
  logic [NUM_REQ*32-1:0] req_q;
  logic [NUM_REQ-1:0]    req_ready;

  // Multiplier datapath side
  logic                  mul_rst;
  logic [31:0]           mul_m;
  logic [31:0]           mul_q;
  logic [63:0]           mul_product;
  logic                  mul_valid;

  // Shared response channel
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [63:0]           rsp_product;
  logic                  rsp_err;
  logic                  rsp_ready;

  modport slave (
    input  req_valid, req_m, req_q, mul_product, mul_valid, rsp_ready,
    output req_ready, mul_rst, mul_m, mul_q, rsp_valid, rsp_id, rsp_product, rsp_err
  );

  modport master (
    output req_valid, req_m, req_q, mul_product, mul_valid, rsp_ready,
    input  req_ready, mul_rst, mul_m, mul_q, rsp_valid, rsp_id, rsp_product, rsp_err
  );
endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one sequential 32x32 signed multiplier between NUM_REQ
// requesters. Round-robin grant in IDLE, one LAUNCH cycle holding the
// multiplier in reset with stable operands, BUSY until mul_valid, then RESP
// until the consumer takes the tagged product.
// Optional feature: define MULT_ARB_TIMEOUT_EN to add a BUSY watchdog that
// aborts after TIMEOUT_CYCLES cycles with rsp_err=1 and a zero product.
module mult_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic           clk,
  input  logic           reset,
  mult_arbiter_if.slave  bus
);

  // Reject configurations the index arithmetic cannot handle.
  if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W != $clog2(NUM_REQ) || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mult_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RESP} state_t;

  state_t          state_reg, state_next;
  logic [ID_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [31:0]     mul_m_reg, mul_m_next;
  logic [31:0]     mul_q_reg, mul_q_next;
  logic            mul_rst_reg, mul_rst_next;
  logic            rsp_valid_reg, rsp_valid_next;
  logic [ID_W-1:0] rsp_id_reg, rsp_id_next;
  logic [63:0]     rsp_product_reg, rsp_product_next;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             rsp_err_reg, rsp_err_next;
`endif

  // Per-requester operand slices.
  logic [31:0] op_m [NUM_REQ];
  logic [31:0] op_q [NUM_REQ];

  // Round-robin search result.
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic            grant_en;
  int              cand;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign op_m[gi] = bus.req_m[32*gi +: 32];
    assign op_q[gi] = bus.req_q[32*gi +: 32];
    // One-hot acceptance pulse, only while IDLE and never during reset.
    assign bus.req_ready[gi] = grant_en && (grant_idx == ID_W'(gi));
  end

  // Find the first active request after the last winner, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_found && bus.req_valid[ID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  assign grant_en = (state_reg == IDLE) && grant_found && !reset;

  // Next-state and next-register values; every target defaults to hold.
  always_comb begin
    state_next       = state_reg;
    rr_ptr_next      = rr_ptr_reg;
    mul_m_next       = mul_m_reg;
    mul_q_next       = mul_q_reg;
    rsp_valid_next   = rsp_valid_reg;
    rsp_id_next      = rsp_id_reg;
    rsp_product_next = rsp_product_reg;
`ifdef MULT_ARB_TIMEOUT_EN
    cnt_next         = cnt_reg;
    rsp_err_next     = rsp_err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          rr_ptr_next = grant_idx;
          mul_m_next  = op_m[grant_idx];
          mul_q_next  = op_q[grant_idx];
          state_next  = LAUNCH;
        end
      end
      LAUNCH: begin
        state_next = BUSY;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_next   = '0;
`endif
      end
      BUSY: begin
        if (bus.mul_valid) begin
          rsp_product_next = bus.mul_product;
          rsp_id_next      = rr_ptr_reg;
          rsp_valid_next   = 1'b1;
          state_next       = RESP;
`ifdef MULT_ARB_TIMEOUT_EN
          rsp_err_next     = 1'b0;
        end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Multiplier never answered: abort with an error response.
          rsp_product_next = '0;
          rsp_id_next      = rr_ptr_reg;
          rsp_valid_next   = 1'b1;
          rsp_err_next     = 1'b1;
          state_next       = RESP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
`endif
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // The multiplier only runs while BUSY; it is held in START otherwise.
    mul_rst_next = (state_next != BUSY);
  end

  // State, operand and response registers; all drop to idle values on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= ID_W'(NUM_REQ - 1);
      mul_m_reg       <= '0;
      mul_q_reg       <= '0;
      mul_rst_reg     <= 1'b1;
      rsp_valid_reg   <= 1'b0;
      rsp_id_reg      <= '0;
      rsp_product_reg <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_reg         <= '0;
      rsp_err_reg     <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      mul_m_reg       <= mul_m_next;
      mul_q_reg       <= mul_q_next;
      mul_rst_reg     <= mul_rst_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_id_reg      <= rsp_id_next;
      rsp_product_reg <= rsp_product_next;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_reg         <= cnt_next;
      rsp_err_reg     <= rsp_err_next;
`endif
    end
  end

  assign bus.mul_rst     = mul_rst_reg;
  assign bus.mul_m       = mul_m_reg;
  assign bus.mul_q       = mul_q_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_id      = rsp_id_reg;
  assign bus.rsp_product = rsp_product_reg;
`ifdef MULT_ARB_TIMEOUT_EN
  assign bus.rsp_err     = rsp_err_reg;
`else
  assign bus.rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Testbench for mult_arbiter: stub sequential multiplier, scoreboard of
// expected responses and grants, one printed line per response.
module tb_mult_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TO      = 24;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [63:0]     product;
    logic            err;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  mult_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  rsp_t exp_q[$];
  int   grant_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  logic [NUM_REQ-1:0] last_grant;
  logic last_hs;
  logic stall;
  int   lat;
  int   mcnt;

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Stub multiplier: restarts while mul_rst is high, answers lat cycles after release.
  initial begin
    bus.mul_valid   = 1'b0;
    bus.mul_product = '0;
    mcnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.mul_rst) begin
        mcnt = 0;
        bus.mul_valid = 1'b0;
      end else begin
        mcnt++;
        if (mcnt == lat && !stall) begin
          bus.mul_valid   = 1'b1;
          bus.mul_product = smul(bus.mul_m, bus.mul_q);
        end else begin
          bus.mul_valid = 1'b0;
        end
      end
    end
  end

  task automatic issue(input int i, input logic [31:0] m, input logic [31:0] q,
                       input logic [63:0] p, input logic err);
    rsp_t e;
    bus.req_valid[i]       = 1'b1;
    bus.req_m[32*i +: 32] = m;
    bus.req_q[32*i +: 32] = q;
    e.id = ID_W'(i);
    e.product = p;
    e.err = err;
    exp_q.push_back(e);
    grant_q.push_back(i);
  endtask

  // Observe one cycle (grant / response handshake), then advance to next negedge.
  task automatic cycle();
    rsp_t e;
    logic [NUM_REQ-1:0] eg;
    #1;
    last_grant = bus.req_ready;
    last_hs    = bus.rsp_valid && bus.rsp_ready;
    if (bus.req_ready != '0) begin
      check("grant_expected", 64'(grant_q.size() != 0), 1);
      if (grant_q.size() != 0) begin
        eg = '0;
        eg[grant_q.pop_front()] = 1'b1;
        check("grant_onehot", bus.req_ready, eg);
      end
    end
    if (last_hs) begin
      $display("rsp id=%0d product=%h err=%0b", bus.rsp_id, bus.rsp_product, bus.rsp_err);
      check("rsp_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_id", bus.rsp_id, e.id);
        check("rsp_product", bus.rsp_product, e.product);
        check("rsp_err", bus.rsp_err, e.err);
      end
    end
    @(negedge clk);
    bus.req_valid = bus.req_valid & ~last_grant;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_mul_rst"}, bus.mul_rst, 1);
    check({tag, "_mul_m"}, bus.mul_m, 0);
    check({tag, "_mul_q"}, bus.mul_q, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_id"}, bus.rsp_id, 0);
    check({tag, "_rsp_product"}, bus.rsp_product, 0);
    check({tag, "_rsp_err"}, bus.rsp_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m, q;
    logic [63:0] p1;
    int n;
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_m = '0;
    bus.req_q = '0;
    bus.rsp_ready = 1'b0;
    stall = 1'b0;
    lat = 3;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b0;

    // Single request with latency checks.
    bus.rsp_ready = 1'b1;
    issue(0, 32'd3, 32'd5, 64'd15, 1'b0);
    cycle();
    check("single_grant_now", last_grant, 4'b0001);
    check("launch_mul_rst", bus.mul_rst, 1);
    check("launch_mul_m", bus.mul_m, 3);
    check("launch_mul_q", bus.mul_q, 5);
    cycle();
    check("busy_entry_mul_rst", bus.mul_rst, 0);
    n = 0;
    while (!bus.mul_valid && n < 20) begin cycle(); n++; end
    check("mul_valid_seen", bus.mul_valid, 1);
    check("rsp_before_valid", bus.rsp_valid, 0);
    cycle();
    check("rsp_one_after_valid", bus.rsp_valid, 1);
    check("resp_mul_rst", bus.mul_rst, 1);
    drain(50);

    // Signed operands.
    lat = 5;
    issue(2, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0);
    drain(50);

    // Simultaneous requests straight after reset: order 0,1,2,3,0.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    lat = 2;
    for (int i = 0; i < NUM_REQ; i++) begin
      m = 32'(-(i * 3 + 1));
      q = 32'(i * 1000 + 77);
      issue(i, m, q, smul(m, q), 1'b0);
    end
    cycle();
    check("simul_first_grant", last_grant, 4'b0001);
    issue(0, 32'h7FFF_FFFF, 32'h8000_0000, smul(32'h7FFF_FFFF, 32'h8000_0000), 1'b0);
    drain(200);

    // Backpressure: hold the response for 10 cycles with another request waiting.
    bus.rsp_ready = 1'b0;
    lat = 4;
    m = 32'h1234_5678;
    q = 32'hFFFF_0001;
    p1 = smul(m, q);
    issue(1, m, q, p1, 1'b0);
    n = 0;
    while (!bus.rsp_valid && n < 30) begin cycle(); n++; end
    check("bp_rsp_valid", bus.rsp_valid, 1);
    issue(3, 32'd100, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FF38, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("bp_hold_valid", bus.rsp_valid, 1);
      check("bp_hold_id", bus.rsp_id, 1);
      check("bp_hold_product", bus.rsp_product, p1);
      check("bp_hold_mul_rst", bus.mul_rst, 1);
      check("bp_no_grant", last_grant, 0);
    end
    bus.rsp_ready = 1'b1;
    cycle();
    check("bp_handshake", last_hs, 1);
    cycle();
    check("bp_grant_after_hs", last_grant, 4'b1000);
    drain(50);

    // Reset while BUSY drops the operation.
    lat = 8;
    issue(2, 32'd9, 32'd9, 64'd81, 1'b0);
    n = 0;
    while (bus.mul_rst && n < 10) begin cycle(); n++; end
    check("rst_busy_reached", bus.mul_rst, 0);
    bus.req_valid[1] = 1'b1;
    reset = 1'b1;
    #1;
    check_reset_outputs("busy_rst");
    exp_q.delete();
    grant_q.delete();
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = '0;
    lat = 3;
    repeat (15) cycle();
    check("no_rsp_after_rst", bus.rsp_valid, 0);
    issue(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b0);
    drain(50);

`ifdef MULT_ARB_TIMEOUT_EN
    // Watchdog: multiplier never answers.
    stall = 1'b1;
    bus.rsp_ready = 1'b0;
    issue(1, 32'd7, 32'd7, 64'd0, 1'b1);
    cycle();
    cycle();
    check("to_busy_entry", bus.mul_rst, 0);
    n = 0;
    while (!bus.rsp_valid && n < TO + 10) begin cycle(); n++; end
    check("to_cycles", n, TO);
    check("to_mul_rst", bus.mul_rst, 1);
    bus.rsp_ready = 1'b1;
    stall = 1'b0;
    drain(20);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
